axi_bram_bridge: RTL

- Parametrised AXI4-Lite slave that gives the ARM PS word-addressed access to a PL block RAM (extended memory, or any other PDP-8 side RAM).
- Next generation of the extended-memory mapper. Adds:
  - generic address/data widths and RAM latencies;
  - fair read/write arbitration;
  - out-of-range SLVERR responses;
  - registered read data.
- Sits between the Zynq GP AXI interconnect and one port of a dual-port BRAM.

---
 rtl/axi_bram_bridge_pkg.sv | 28 ++
 rtl/axi_bram_bridge_arb.sv | 33 +++
 rtl/axi_bram_bridge.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_bram_bridge_pkg.sv
// rtl/axi_bram_bridge_pkg.sv - response codes, FSM states and width helper for the AXI-Lite BRAM bridge
package axi_bram_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RDRSP,
      ST_WR,
      ST_WRRSP,
      ST_RMW
   } state_e;

   typedef enum logic {
      GNT_RD = 1'b0,
      GNT_WR = 1'b1
   } grant_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_bram_bridge_arb.sv
// rtl/axi_bram_bridge_arb.sv - two-request round-robin grant; the last granted type loses a tie
module axi_bram_arb
   import axi_bram_pkg::*;
(
   input  logic CLOCK,
   input  logic RESET_N,
   input  logic en,
   input  logic rd_req,
   input  logic wr_req,
   output logic gnt_rd,
   output logic gnt_wr
);

   grant_e lastgrant_q, lastgrant_d;

   always_comb begin
      gnt_rd      = en & rd_req & (~wr_req | (lastgrant_q == GNT_WR));
      gnt_wr      = en & wr_req & (~rd_req | (lastgrant_q == GNT_RD));
      lastgrant_d = lastgrant_q;
      if (gnt_rd)
         lastgrant_d = GNT_RD;
      else if (gnt_wr)
         lastgrant_d = GNT_WR;
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET_N)
         lastgrant_q <= GNT_WR;
      else
         lastgrant_q <= lastgrant_d;
   end

endmodule

// File: rtl/axi_bram_bridge.sv
// rtl/axi_bram_bridge.sv - AXI4-Lite slave onto one BRAM port; AXIBRAM_WSTRB_EN adds strobe read-modify-write
module axi_bram_bridge
   import axi_bram_pkg::*;
#(
   parameter int AW     = 15,
   parameter int DW     = 12,
   parameter int NWORDS = 1 << AW,
   parameter int RDLAT  = 2,
   parameter int WRLAT  = 3
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   output logic [AW-1:0] xbraddr,
   output logic [DW-1:0] xbrwdat,
   input  logic [DW-1:0] xbrrdat,
   output logic          xbrenab,
   output logic          xbrwena,
   input  logic [AW+1:0] saxi_ARADDR,
   input  logic          saxi_ARVALID,
   output logic          saxi_ARREADY,
   output logic [31:0]   saxi_RDATA,
   output logic [1:0]    saxi_RRESP,
   output logic          saxi_RVALID,
   input  logic          saxi_RREADY,
   input  logic [AW+1:0] saxi_AWADDR,
   input  logic          saxi_AWVALID,
   output logic          saxi_AWREADY,
   input  logic [31:0]   saxi_WDATA,
   input  logic [3:0]    saxi_WSTRB,
   input  logic          saxi_WVALID,
   output logic          saxi_WREADY,
   output logic [1:0]    saxi_BRESP,
   output logic          saxi_BVALID,
   input  logic          saxi_BREADY
);

   localparam int CW = clog2(((RDLAT > WRLAT) ? RDLAT : WRLAT) + 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          arready_q, arready_d, awready_q, awready_d, wready_q, wready_d;
   logic          rvalid_q, rvalid_d, bvalid_q, bvalid_d;
   logic          rd_active_q, rd_active_d, wr_active_q, wr_active_d;
   logic [1:0]    rresp_q, rresp_d, bresp_q, bresp_d;
   logic [DW-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
   logic [AW-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
   logic          gnt_rd, gnt_wr;
   logic          unused_bits;

`ifdef AXIBRAM_WSTRB_EN
   logic [1:0]    wstrb_q, wstrb_d;
   logic [DW-1:0] strb_mask;

   always_comb begin
      strb_mask = '0;
      for (int i = 0; i < DW; i++)
         strb_mask[i] = (i < 8) ? wstrb_q[0] : wstrb_q[1];
   end

   assign unused_bits = ^{saxi_ARADDR[1:0], saxi_AWADDR[1:0], saxi_WDATA[31:DW], saxi_WSTRB[3:2]};
`else
   assign unused_bits = ^{saxi_ARADDR[1:0], saxi_AWADDR[1:0], saxi_WDATA[31:DW], saxi_WSTRB};
`endif

   function automatic logic in_range(input logic [AW-1:0] a);
      return 32'(a) < 32'(NWORDS);
   endfunction

   axi_bram_arb u_arb (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .en      (state_q == ST_IDLE),
      .rd_req  (~arready_q & ~rd_active_q),
      .wr_req  (~awready_q & ~wready_q & ~wr_active_q),
      .gnt_rd  (gnt_rd),
      .gnt_wr  (gnt_wr)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      arready_d   = arready_q;
      awready_d   = awready_q;
      wready_d    = wready_q;
      rvalid_d    = rvalid_q;
      bvalid_d    = bvalid_q;
      rd_active_d = rd_active_q;
      wr_active_d = wr_active_q;
      rresp_d     = rresp_q;
      bresp_d     = bresp_q;
      rdata_d     = rdata_q;
      wdata_d     = wdata_q;
      araddr_d    = araddr_q;
      awaddr_d    = awaddr_q;
`ifdef AXIBRAM_WSTRB_EN
      wstrb_d     = wstrb_q;
`endif

      // Channel capture and release; a READY stays low until its response is taken.
      if (saxi_ARVALID && arready_q) begin
         arready_d = 1'b0;
         araddr_d  = saxi_ARADDR[AW+1:2];
      end
      if (rvalid_q && saxi_RREADY) begin
         rvalid_d    = 1'b0;
         arready_d   = 1'b1;
         rd_active_d = 1'b0;
      end
      if (saxi_AWVALID && awready_q) begin
         awready_d = 1'b0;
         awaddr_d  = saxi_AWADDR[AW+1:2];
      end
      if (saxi_WVALID && wready_q) begin
         wready_d = 1'b0;
         wdata_d  = saxi_WDATA[DW-1:0];
`ifdef AXIBRAM_WSTRB_EN
         wstrb_d  = saxi_WSTRB[1:0];
`endif
      end
      if (bvalid_q && saxi_BREADY) begin
         bvalid_d    = 1'b0;
         awready_d   = 1'b1;
         wready_d    = 1'b1;
         wr_active_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (gnt_rd) begin
               rd_active_d = 1'b1;
               if (in_range(araddr_q)) begin
                  state_d = ST_RD;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
                  state_d = ST_RDRSP;
               end
            end else if (gnt_wr) begin
               wr_active_d = 1'b1;
               bresp_d     = RESP_OKAY;
               if (!in_range(awaddr_q)) begin
                  bresp_d = RESP_SLVERR;
                  state_d = ST_WRRSP;
               end
`ifdef AXIBRAM_WSTRB_EN
               else if (strb_mask == '0)
                  state_d = ST_WRRSP;
               else if (strb_mask != '1)
                  state_d = ST_RMW;
`endif
               else
                  state_d = ST_WR;
            end
         end
         ST_RD: begin
            if (cnt_q == CW'(RDLAT - 1)) begin
               rdata_d = xbrrdat;
               rresp_d = RESP_OKAY;
               state_d = ST_RDRSP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RDRSP: begin
            rvalid_d = 1'b1;
            state_d  = ST_IDLE;
         end
         ST_RMW: begin
`ifdef AXIBRAM_WSTRB_EN
            if (cnt_q == CW'(RDLAT - 1)) begin
               wdata_d = (xbrrdat & ~strb_mask) | (wdata_q & strb_mask);
               cnt_d   = '0;
               state_d = ST_WR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_WR: begin
            if (cnt_q == CW'(WRLAT - 1))
               state_d = ST_WRRSP;
            else
               cnt_d = cnt_q + CW'(1);
         end
         ST_WRRSP: begin
            bvalid_d = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         arready_q   <= 1'b1;
         awready_q   <= 1'b1;
         wready_q    <= 1'b1;
         rvalid_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         rd_active_q <= 1'b0;
         wr_active_q <= 1'b0;
         rresp_q     <= RESP_OKAY;
         bresp_q     <= RESP_OKAY;
         rdata_q     <= '0;
         wdata_q     <= '0;
         araddr_q    <= '0;
         awaddr_q    <= '0;
`ifdef AXIBRAM_WSTRB_EN
         wstrb_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         arready_q   <= arready_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         rvalid_q    <= rvalid_d;
         bvalid_q    <= bvalid_d;
         rd_active_q <= rd_active_d;
         wr_active_q <= wr_active_d;
         rresp_q     <= rresp_d;
         bresp_q     <= bresp_d;
         rdata_q     <= rdata_d;
         wdata_q     <= wdata_d;
         araddr_q    <= araddr_d;
         awaddr_q    <= awaddr_d;
`ifdef AXIBRAM_WSTRB_EN
         wstrb_q     <= wstrb_d;
`endif
      end
   end

   assign xbrenab      = state_q inside {ST_RD, ST_WR, ST_RMW};
   assign xbrwena      = (state_q == ST_WR);
   assign xbraddr      = (state_q == ST_WR || state_q == ST_RMW) ? awaddr_q : araddr_q;
   assign xbrwdat      = wdata_q;
   assign saxi_ARREADY = arready_q;
   assign saxi_AWREADY = awready_q;
   assign saxi_WREADY  = wready_q;
   assign saxi_RVALID  = rvalid_q;
   assign saxi_BVALID  = bvalid_q;
   assign saxi_RDATA   = {{(32 - DW){1'b0}}, rdata_q};
   assign saxi_RRESP   = rresp_q;
   assign saxi_BRESP   = bresp_q;

endmodule
